// File: rtl/lsu_ctrl_if.sv
// lsu_ctrl_if: core-side request/response and data-memory
// byte-enable request/response bundle for the load/store unit.
// Ports (slave = LSU side):
//   core_valid/ready/we/func3/addr/wdata : request from execute
//   core_done/err/rdata                  : completion to core
//   mem_req/we/addr/be/wdata, mem_gnt    : memory request channel
//   mem_rvalid/rdata                     : memory read response
interface lsu_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              core_valid;
  logic              core_ready;
  logic              core_we;
  logic [2:0]        core_func3;
  logic [ADDR_W-1:0] core_addr;
  logic [31:0]       core_wdata;
  logic              core_done;
  logic              core_err;
  logic [31:0]       core_rdata;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wdata;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [31:0]       mem_rdata;

  modport master (
    output core_valid, core_we, core_func3,
    output core_addr, core_wdata,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  core_ready, core_done, core_err,
    input  core_rdata,
    input  mem_req, mem_we, mem_addr,
    input  mem_be, mem_wdata
  );

  modport slave (
    input  core_valid, core_we, core_func3,
    input  core_addr, core_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output core_ready, core_done, core_err,
    output core_rdata,
    output mem_req, mem_we, mem_addr,
    output mem_be, mem_wdata
  );
endinterface

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store unit, word-aligned byte-enable requests,
// load merge and extension. Ports: clk, rst (sync, active high),
// bus (lsu_ctrl_if.slave). Macro LSU_MISALIGN_SPLIT_EN enables
// misaligned access (two beats when crossing a word); otherwise
// misaligned accesses fault without touching memory.
module lsu_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic      clk,
  input  logic      rst,
  lsu_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    REQ1,
    WAIT1,
`ifdef LSU_MISALIGN_SPLIT_EN
    REQ2,
    WAIT2,
`endif
    DONE
  } state_t;

  state_t            state_q, state_d;
  logic              we_q;
  logic [2:0]        f3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic              err_q;
  logic [31:0]       tmo_q;

  logic              accept;
  logic              in_fault;
  logic              tmo_hit;
  logic              tmo_err;
  logic              ld_fin;
  logic [31:0]       ld_val;
  logic [1:0]        off;
  logic [3:0]        mask;
  logic [3:0]        be1;
  logic [31:0]       wd1;
  logic [ADDR_W-1:0] base;

  assign accept  = bus.core_valid & bus.core_ready;
  assign off     = addr_q[1:0];
  assign base    = {addr_q[ADDR_W-1:2], 2'b00};
  assign be1     = mask << off;
  assign wd1     = wdata_q << {off, 3'b000};
  assign tmo_hit = (TIMEOUT != 0) &&
                   (tmo_q == 32'(TIMEOUT - 1));

  always_comb begin
    case (f3_q[1:0])
      2'b00:   mask = 4'b0001;
      2'b01:   mask = 4'b0011;
      default: mask = 4'b1111;
    endcase
  end

`ifdef LSU_MISALIGN_SPLIT_EN
  logic [31:0]       rd1_q;
  logic [2:0]        size3;
  logic [2:0]        sh2;
  logic              cross;
  logic [3:0]        be2;
  logic [31:0]       wd2;

  // sh2: byte distance from the access start to the next word
  assign size3 = (f3_q[1:0] == 2'b00) ? 3'd1 :
                 (f3_q[1:0] == 2'b01) ? 3'd2 : 3'd4;
  assign sh2   = 3'd4 - {1'b0, off};
  assign cross = ({1'b0, off} + size3) > 3'd4;
  assign be2   = mask >> sh2;
  assign wd2   = wdata_q >> {sh2, 3'b000};
`endif

  // Fault check on the incoming request, decided at accept
  always_comb begin
    logic [2:0] f3;
    logic       bad;
    f3 = bus.core_func3;
    if (bus.core_we)
      bad = f3[2] | (f3[1:0] == 2'b11);
    else
      bad = (f3[1:0] == 2'b11) | (f3[2] & f3[1]);
`ifdef LSU_MISALIGN_SPLIT_EN
    in_fault = bad;
`else
    in_fault = bad |
      ((f3[1:0] == 2'b01) & bus.core_addr[0]) |
      ((f3[1:0] == 2'b10) & (bus.core_addr[1:0] != 2'b00));
`endif
  end

  function automatic logic [31:0] ext(
    input logic [2:0]  f3,
    input logic [31:0] v
  );
    case (f3[1:0])
      2'b00:   ext = f3[2] ? {24'b0, v[7:0]}
                           : {{24{v[7]}}, v[7:0]};
      2'b01:   ext = f3[2] ? {16'b0, v[15:0]}
                           : {{16{v[15]}}, v[15:0]};
      default: ext = v;
    endcase
  endfunction

  always_comb begin
    state_d       = state_q;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_be    = 4'b0000;
    bus.mem_wdata = 32'b0;
    tmo_err       = 1'b0;
    ld_fin        = 1'b0;
    ld_val        = 32'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) state_d = in_fault ? DONE : REQ1;
      end
      REQ1: begin
        bus.mem_req   = 1'b1;
        bus.mem_we    = we_q;
        bus.mem_addr  = base;
        bus.mem_be    = be1;
        bus.mem_wdata = wd1;
        if (bus.mem_gnt) begin
`ifdef LSU_MISALIGN_SPLIT_EN
          if (we_q) state_d = cross ? REQ2 : DONE;
`else
          if (we_q) state_d = DONE;
`endif
          else      state_d = WAIT1;
        end else if (tmo_hit) begin
          state_d = DONE;
          tmo_err = 1'b1;
        end
      end
      WAIT1: begin
        if (bus.mem_rvalid) begin
`ifdef LSU_MISALIGN_SPLIT_EN
          if (cross) begin
            state_d = REQ2;
          end else begin
            state_d = DONE;
            ld_fin  = 1'b1;
            ld_val  = bus.mem_rdata >> {off, 3'b000};
          end
`else
          state_d = DONE;
          ld_fin  = 1'b1;
          ld_val  = bus.mem_rdata >> {off, 3'b000};
`endif
        end else if (tmo_hit) begin
          state_d = DONE;
          tmo_err = 1'b1;
        end
      end
`ifdef LSU_MISALIGN_SPLIT_EN
      REQ2: begin
        bus.mem_req   = 1'b1;
        bus.mem_we    = we_q;
        bus.mem_addr  = base + ADDR_W'(4);
        bus.mem_be    = be2;
        bus.mem_wdata = wd2;
        if (bus.mem_gnt) begin
          state_d = we_q ? DONE : WAIT2;
        end else if (tmo_hit) begin
          state_d = DONE;
          tmo_err = 1'b1;
        end
      end
      WAIT2: begin
        if (bus.mem_rvalid) begin
          state_d = DONE;
          ld_fin  = 1'b1;
          ld_val  = (rd1_q >> {off, 3'b000}) |
                    (bus.mem_rdata << {sh2, 3'b000});
        end else if (tmo_hit) begin
          state_d = DONE;
          tmo_err = 1'b1;
        end
      end
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= '0;
      wdata_q <= 32'b0;
      rdata_q <= 32'b0;
      err_q   <= 1'b0;
      tmo_q   <= 32'b0;
`ifdef LSU_MISALIGN_SPLIT_EN
      rd1_q   <= 32'b0;
`endif
    end else begin
      state_q <= state_d;
      if (state_d != state_q || state_q == IDLE)
        tmo_q <= 32'b0;
      else
        tmo_q <= tmo_q + 32'd1;
      if (accept) begin
        we_q    <= bus.core_we;
        f3_q    <= bus.core_func3;
        addr_q  <= bus.core_addr;
        wdata_q <= bus.core_wdata;
        err_q   <= in_fault;
      end
      if (tmo_err) err_q <= 1'b1;
      if (ld_fin)  rdata_q <= ext(f3_q, ld_val);
`ifdef LSU_MISALIGN_SPLIT_EN
      if (state_q == WAIT1 && bus.mem_rvalid)
        rd1_q <= bus.mem_rdata;
`endif
    end
  end

  assign bus.core_ready = (state_q == IDLE);
  assign bus.core_done  = (state_q == DONE);
  assign bus.core_err   = (state_q == DONE) & err_q;
  assign bus.core_rdata = rdata_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: scoreboard bench for lsu_ctrl; a memory responder
// checks each beat, a monitor checks each completion.
module tb_lsu_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lsu_ctrl_if #(.ADDR_W(32)) bus();
  lsu_ctrl #(.ADDR_W(32), .TIMEOUT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          gnt_dly;
    int          rv_dly;
    int          req_cyc;
    logic [31:0] rdata;
  } beat_t;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          lat;
  } rsp_t;

  beat_t       beat_q[$];
  rsp_t        rsp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          last_acc = 0;
  logic [31:0] last_rd = 32'h0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic exp_beat(input logic we, input logic [31:0] a,
                          input logic [3:0] be, input logic [31:0] wd,
                          input int gd, input int rvd,
                          input logic [31:0] rd);
    beat_t b;
    b.we = we; b.addr = a; b.be = be; b.wdata = wd;
    b.gnt_dly = gd; b.rv_dly = rvd; b.req_cyc = 4; b.rdata = rd;
    beat_q.push_back(b);
  endtask

  task automatic exp_rsp(input logic err, input logic [31:0] rd,
                         input int lat);
    rsp_t r;
    r.err = err; r.rdata = rd; r.lat = lat;
    rsp_q.push_back(r);
    last_rd = rd;
  endtask

  task automatic issue(input logic we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
    int n = 0;
    while (!bus.core_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.core_ready) chk("ready_wait", 64'(bus.core_ready), 64'd1);
    bus.core_valid = 1'b1;
    bus.core_we    = we;
    bus.core_func3 = f3;
    bus.core_addr  = a;
    bus.core_wdata = wd;
    last_acc       = cyc;
    @(negedge clk);
    bus.core_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((rsp_q.size() != 0 || beat_q.size() != 0 ||
            !bus.core_ready) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 64'(rsp_q.size() + beat_q.size()), 64'd0);
    @(negedge clk);
  endtask

  // Memory responder
  initial begin
    beat_t b;
    int    n;
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = 32'h0;
    forever begin
      @(negedge clk);
      if (bus.mem_req === 1'b1) begin
        if (beat_q.size() == 0) begin
          chk("unexp_req", 64'(beat_q.size()), 64'd1);
        end else begin
          b = beat_q.pop_front();
          chk("mem_addr", 64'(bus.mem_addr), 64'(b.addr));
          chk("mem_be", 64'(bus.mem_be), 64'(b.be));
          chk("mem_we", 64'(bus.mem_we), 64'(b.we));
          if (b.we) chk("mem_wdata", 64'(bus.mem_wdata), 64'(b.wdata));
          if (b.gnt_dly < 0) begin
            n = 1;
            while (n < 40) begin
              @(negedge clk);
              if (bus.mem_req !== 1'b1) break;
              n++;
            end
            chk("req_cycles", 64'(n), 64'(b.req_cyc));
          end else begin
            for (int i = 0; i < b.gnt_dly; i++) begin
              @(negedge clk);
              chk("req_hold", {27'b0, bus.mem_req, bus.mem_be, bus.mem_addr},
                  {27'b0, 1'b1, b.be, b.addr});
            end
            bus.mem_gnt = 1'b1;
            @(negedge clk);
            bus.mem_gnt = 1'b0;
            if (!b.we) begin
              for (int i = 1; i < b.rv_dly; i++) @(negedge clk);
              bus.mem_rvalid = 1'b1;
              bus.mem_rdata  = b.rdata;
              @(negedge clk);
              bus.mem_rvalid = 1'b0;
              bus.mem_rdata  = 32'h0;
            end
          end
        end
      end
    end
  end

  // Completion monitor
  initial begin
    rsp_t r;
    forever begin
      @(negedge clk);
      if (bus.core_done === 1'b1) begin
        if (rsp_q.size() == 0) begin
          chk("unexp_done", 64'(rsp_q.size()), 64'd1);
        end else begin
          r = rsp_q.pop_front();
          chk("core_err", 64'(bus.core_err), 64'(r.err));
          chk("core_rdata", 64'(bus.core_rdata), 64'(r.rdata));
          if (r.lat >= 0)
            chk("latency", 64'(cyc - last_acc), 64'(r.lat));
        end
      end else if (bus.core_err === 1'b1) begin
        chk("err_no_done", 64'(bus.core_done), 64'd1);
      end
    end
  end

  initial begin
    rst            = 1'b1;
    bus.core_valid = 1'b0;
    bus.core_we    = 1'b0;
    bus.core_func3 = 3'b000;
    bus.core_addr  = 32'h0;
    bus.core_wdata = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 64'(bus.core_ready), 64'd1);
    chk("rst_done", 64'(bus.core_done), 64'd0);
    chk("rst_err", 64'(bus.core_err), 64'd0);
    chk("rst_req", 64'(bus.mem_req), 64'd0);
    chk("rst_be", 64'(bus.mem_be), 64'd0);
    chk("rst_rdata", 64'(bus.core_rdata), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // SW aligned, immediate grant
    exp_beat(1, 32'h100, 4'hF, 32'hDEADBEEF, 0, 1, 0);
    exp_rsp(0, last_rd, 2);
    issue(1, 3'b010, 32'h100, 32'hDEADBEEF); drain();
    // SB top lane
    exp_beat(1, 32'h100, 4'h8, 32'hA5000000, 0, 1, 0);
    exp_rsp(0, last_rd, 2);
    issue(1, 3'b000, 32'h103, 32'h000000A5); drain();
    // LB / LBU
    exp_beat(0, 32'h100, 4'h8, 0, 0, 1, 32'hA5000000);
    exp_rsp(0, 32'hFFFFFFA5, 3);
    issue(0, 3'b000, 32'h103, 0); drain();
    exp_beat(0, 32'h100, 4'h8, 0, 0, 1, 32'hA5000000);
    exp_rsp(0, 32'h000000A5, 3);
    issue(0, 3'b100, 32'h103, 0); drain();
    // LH with grant delayed 3 cycles, LHU
    exp_beat(0, 32'h100, 4'hC, 0, 3, 1, 32'h80010000);
    exp_rsp(0, 32'hFFFF8001, 6);
    issue(0, 3'b001, 32'h102, 0); drain();
    exp_beat(0, 32'h100, 4'hC, 0, 0, 1, 32'h80010000);
    exp_rsp(0, 32'h00008001, 3);
    issue(0, 3'b101, 32'h102, 0); drain();

`ifdef LSU_MISALIGN_SPLIT_EN
    exp_beat(0, 32'h1FC, 4'hC, 0, 0, 1, 32'hBBAA0000);
    exp_beat(0, 32'h200, 4'h3, 0, 0, 1, 32'h0000DDCC);
    exp_rsp(0, 32'hDDCCBBAA, -1);
    issue(0, 3'b010, 32'h1FE, 0); drain();
    exp_beat(0, 32'h100, 4'h6, 0, 0, 1, 32'h00BEEF00);
    exp_rsp(0, 32'hFFFFBEEF, 3);
    issue(0, 3'b001, 32'h101, 0); drain();
    exp_beat(1, 32'h100, 4'h8, 32'h34000000, 0, 1, 0);
    exp_beat(1, 32'h104, 4'h1, 32'h00000012, 0, 1, 0);
    exp_rsp(0, last_rd, -1);
    issue(1, 3'b001, 32'h103, 32'h00001234); drain();
`else
    exp_rsp(1, last_rd, 1);
    issue(0, 3'b010, 32'h1FE, 0); drain();
    exp_rsp(1, last_rd, 1);
    issue(0, 3'b001, 32'h101, 0); drain();
    exp_rsp(1, last_rd, 1);
    issue(1, 3'b001, 32'h103, 32'h00001234); drain();
`endif

    // Illegal func3
    exp_rsp(1, last_rd, 1);
    issue(0, 3'b011, 32'h100, 0); drain();
    exp_rsp(1, last_rd, 1);
    issue(1, 3'b100, 32'h100, 0); drain();
    exp_rsp(1, last_rd, 1);
    issue(0, 3'b110, 32'h100, 0); drain();

    // Reset while in WAIT1; late rvalid must be ignored
    exp_beat(0, 32'h100, 4'hF, 0, 0, 3, 32'h11111111);
    issue(0, 3'b010, 32'h100, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    last_rd = 32'h0;
    chk("midrst_ready", 64'(bus.core_ready), 64'd1);
    chk("midrst_req", 64'(bus.mem_req), 64'd0);
    chk("midrst_rdata", 64'(bus.core_rdata), 64'd0);
    repeat (6) @(negedge clk);
    chk("midrst_beats", 64'(beat_q.size()), 64'd0);

    // Timeout: grant never arrives
    exp_beat(1, 32'h100, 4'hF, 32'hCAFEF00D, -1, 1, 0);
    exp_rsp(1, last_rd, 5);
    issue(1, 3'b010, 32'h100, 32'hCAFEF00D); drain();
    chk("tmo_req_low", 64'(bus.mem_req), 64'd0);

    // Recovery load
    exp_beat(0, 32'h104, 4'hF, 0, 0, 1, 32'h12345678);
    exp_rsp(0, 32'h12345678, 3);
    issue(0, 3'b010, 32'h104, 0); drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Core-side load/store unit that initiates all data-memory transactions for the single-cycle/multi-cycle datapath.
- Takes a decoded load/store (func3, byte address, store data) from the core and converts it into word-aligned memory requests with byte enables.
- Waits on the memory handshake, then extracts, merges and sign/zero-extends load data.
- Sits between the execute stage and the data memory's byte-enable request/response port.

Parameters:
- ADDR_W, 32, byte-address width on core and memory sides.
- TIMEOUT, 255, cycles to wait for mem_gnt/mem_rvalid before aborting with error; 0 disables.

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- core_valid  input  1  request from core, held until accepted
- core_ready  output  1  high only in IDLE; accept = core_valid & core_ready
- core_we  input  1  1 = store, 0 = load
- core_func3  input  3  LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010
- core_addr  input  ADDR_W  byte address
- core_wdata  input  32  store data, right-justified
- core_done  output  1  one-cycle pulse, transaction finished
- core_err  output  1  one-cycle pulse, coincident with core_done, on fault
- core_rdata  output  32  extended load result, valid with core_done, held until next done
- mem_req  output  1  request, held until mem_gnt
- mem_we  output  1  write request
- mem_addr  output  ADDR_W  word-aligned (bits [1:0] = 0)
- mem_be  output  4  byte enables
- mem_wdata  output  32  lane-aligned store data
- mem_gnt  input  1  request accepted this cycle
- mem_rvalid  input  1  read data valid, at least 1 cycle after read gnt
- mem_rdata  input  32  read word

Behaviour:
- Reset: all outputs 0 except core_ready = 1; state IDLE; capture registers cleared.
- Reset mid-operation: return to IDLE at the same edge and drop mem_req. A stale mem_rvalid arriving in IDLE is ignored.
- Capture on accept: we, func3, addr, wdata. Derived values:
  - off = addr[1:0]
  - size = 1/2/4 from func3[1:0]
  - misaligned = (half & off[0]) | (word & off != 0)
  - cross = off + size > 4
- Illegal func3 (load 011/11x; store ≥ 011): no memory access; next cycle core_done = core_err = 1, core_rdata unchanged.
- States: IDLE → REQ1 → (load) WAIT1 → [REQ2 → WAIT2] → DONE → IDLE.
  - Stores skip WAIT*: complete on gnt.
  - Second phase only when cross.
- REQ phase: mem_req = 1, all mem_* stable until the mem_gnt cycle. The edge with gnt advances the state.
- Phase 1 (first beat):
  - mem_addr = {addr[ADDR_W-1:2], 00}
  - mem_be = ((1<<size)-1) << off, truncated to 4 bits
  - mem_wdata = wdata << 8*off
- Phase 2 (second beat):
  - mem_addr = phase-1 address + 4, wrapping modulo 2^ADDR_W
  - mem_be = ((1<<size)-1) >> (4-off)
  - mem_wdata = wdata >> 8*(4-off)
- Load merge:
  - Phase-1 rdata >> 8*off fills the low bytes.
  - Phase-2 rdata << 8*(4-off) fills the upper bytes.
  - Result truncated to size, then sign-extended (LB/LH) or zero-extended (LBU/LHU).
- DONE: single cycle; core_done = 1, core_rdata registered. core_ready returns next cycle.
- Latency:
  - Aligned store with immediate gnt: accept at T, mem_req at T+1, done at T+2.
  - Aligned load with gnt at T+1 and rvalid at T+2: done at T+3.
- mem_rvalid seen in REQ states (before gnt) is ignored.
- Timeout (TIMEOUT ≠ 0): counter resets on every state change. Reaching TIMEOUT → DONE with core_err = 1 and mem_req dropped. Partial split stores are not rolled back.
- mem_we = captured we during REQ states, else 0. mem_be = 0 when mem_req = 0.

Optional Feature:
- Macro: LSU_MISALIGN_SPLIT_EN.
- Defined: misaligned accesses are supported.
  - Non-crossing ones use a single beat (e.g. LH at off 1 → be 0110).
  - Crossing ones use two beats as above.
- Undefined: any misaligned access is faulted with no memory access; core_done = core_err = 1 the cycle after accept. REQ2/WAIT2 are not built.

Test Plan:
- Reset, then SW addr 0x100, data 0xDEADBEEF, gnt immediate → mem_addr 0x100, be 1111, wdata 0xDEADBEEF; done at T+2, err 0.
- SB addr 0x103, data 0x000000A5 → be 1000, wdata 0xA5000000. Then LB 0x103 with rdata 0xA5000000 → core_rdata 0xFFFFFFA5; LBU → 0x000000A5.
- LH addr 0x102, rdata 0x80010000, gnt delayed 3 cycles (mem_req held stable) → core_rdata 0xFFFF8001. LHU → 0x00008001.
- With LSU_MISALIGN_SPLIT_EN, LW addr 0x1FE: beat 1 0x1FC be 1100 rdata 0xBBAA0000; beat 2 0x200 be 0011 rdata 0x0000DDCC → core_rdata 0xDDCCBBAA. Without the macro: no mem_req, err pulse.
- Illegal func3 011 load → no mem_req, core_done = core_err = 1. rst asserted while in WAIT1 → IDLE next edge; a late rvalid is ignored and core_done stays 0.
- TIMEOUT = 4, mem_gnt never asserted → mem_req high 4 cycles, then core_done = core_err = 1, mem_req 0.
